// File: rtl/hline_pkg.sv
// Shared definitions for the horizontal-line memory port: FSM state
// encoding, AXI response codes and address/strobe helpers.
package hline_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Widest address the helpers accept; callers zero-extend into it.
    localparam int unsigned MAX_ADDR_W = 64;

    // Word-align a byte address (AXI bus is 32 bits wide).
    function automatic logic [MAX_ADDR_W-1:0] align_word(input logic [MAX_ADDR_W-1:0] a);
        return a & ~MAX_ADDR_W'(3);
    endfunction

    // Place the halfword lane enables into the upper or lower half of wstrb.
    function automatic logic [3:0] lane_strb(input logic hi_half, input logic [1:0] be);
        return hi_half ? {be, 2'b00} : {2'b00, be};
    endfunction

endpackage

// File: rtl/hline_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Ports: clk/reset (sync, active-high); push/push_data write side (push
// ignored when full); pop pops the head (ignored when empty); head is the
// oldest word, valid whenever empty is low; count is the occupancy.
module hline_sync_fifo
    import hline_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (cnt != CNT_W'(DEPTH));
    assign do_pop  = pop && (cnt != '0);

    // Storage and pointers; DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/hline_mem_port.sv
// Memory-side responder for the horizontal-line z-buffer engine.
// Turns single-outstanding rd_req/wr_req from the line FSM into AXI4-Lite
// reads/writes, queues read words in a FWFT z-read FIFO and pulses axi_done
// on completion. err is sticky on any non-OKAY response.
// Ports: clk/reset (sync, active-high); rd_req/wr_req/addr/byteenable/wdata
// request side; read_zfifo/zfifo_in/zread_empty z-read FIFO; axi_done, err
// status; m_* AXI4-Lite master channels.
module hline_mem_port
    import hline_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        byteenable,
    input  logic [31:0]       wdata,
    input  logic              read_zfifo,
    output logic [31:0]       zfifo_in,
    output logic              zread_empty,
    output logic              axi_done,
    output logic              err,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        strb_q;
    logic [31:0]       wdata_q;
    logic              arvalid_q, arvalid_nxt;
    logic              rready_q, rready_nxt;
    logic              awvalid_q, awvalid_nxt;
    logic              wvalid_q, wvalid_nxt;
    logic              bready_q, bready_nxt;
    logic              done_q, done_nxt;
    logic              err_q, err_nxt;
    logic              capture_rd;
    logic              capture_wr;
    logic              fifo_push;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_room;

    assign fifo_room = (fifo_count < CNT_W'(FIFO_DEPTH));

    // Next state and next values of the registered AXI/status outputs.
    always_comb begin
        state_nxt   = state;
        arvalid_nxt = 1'b0;
        rready_nxt  = 1'b0;
        awvalid_nxt = 1'b0;
        wvalid_nxt  = 1'b0;
        bready_nxt  = 1'b0;
        done_nxt    = 1'b0;
        err_nxt     = err_q;
        capture_rd  = 1'b0;
        capture_wr  = 1'b0;
        fifo_push   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                // The request is still held during the done cycle; ignore it.
                // A read blocked on a full FIFO also blocks any write.
                if (!done_q) begin
                    if (rd_req) begin
                        if (fifo_room) begin
                            capture_rd  = 1'b1;
                            arvalid_nxt = 1'b1;
                            state_nxt   = ST_RD_ADDR;
                        end
                    end else if (wr_req) begin
                        capture_wr  = 1'b1;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        state_nxt   = ST_WR_REQ;
                    end
                end
            end
            ST_RD_ADDR: begin
                arvalid_nxt = 1'b1;
                if (m_arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                rready_nxt = 1'b1;
                if (m_rvalid) begin
                    rready_nxt = 1'b0;
                    fifo_push  = 1'b1;
                    done_nxt   = 1'b1;
                    err_nxt    = err_q | (m_rresp != RESP_OKAY);
                    state_nxt  = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                // Address and data channels retire independently.
                awvalid_nxt = awvalid_q & ~m_awready;
                wvalid_nxt  = wvalid_q & ~m_wready;
                if (!awvalid_nxt && !wvalid_nxt) begin
                    bready_nxt = 1'b1;
                    state_nxt  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                bready_nxt = 1'b1;
                if (m_bvalid) begin
                    bready_nxt = 1'b0;
                    done_nxt   = 1'b1;
                    err_nxt    = err_q | (m_bresp != RESP_OKAY);
                    state_nxt  = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, output and request-capture registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            strb_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state     <= state_nxt;
            arvalid_q <= arvalid_nxt;
            rready_q  <= rready_nxt;
            awvalid_q <= awvalid_nxt;
            wvalid_q  <= wvalid_nxt;
            bready_q  <= bready_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
            if (capture_rd || capture_wr) begin
                addr_q <= ADDR_W'(align_word(MAX_ADDR_W'(addr)));
            end
            if (capture_wr) begin
                strb_q  <= lane_strb(addr[1], byteenable);
                wdata_q <= wdata;
            end
        end
    end

    hline_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_zfifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (m_rdata),
        .pop       (read_zfifo),
        .head      (zfifo_in),
        .empty     (zread_empty),
        .count     (fifo_count)
    );

    assign m_araddr  = addr_q;
    assign m_awaddr  = addr_q;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;
    assign m_awvalid = awvalid_q;
    assign m_wvalid  = wvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = strb_q;
    assign m_bready  = bready_q;
    assign axi_done  = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_hline_mem_port.sv
// Directed bench for hline_mem_port: zero-wait reads/writes, delayed
// awready, full-FIFO stall, read/write priority, sticky err, mid-read reset.
module tb_hline_mem_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req, wr_req;
    logic [31:0] addr;
    logic [1:0]  byteenable;
    logic [31:0] wdata;
    logic        read_zfifo;
    logic [31:0] zfifo_in;
    logic        zread_empty, axi_done, err;
    logic [31:0] m_araddr;
    logic        m_arvalid, m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid, m_rready;
    logic [31:0] m_awaddr;
    logic        m_awvalid, m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid, m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid, m_bready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hline_mem_port #(
        .FIFO_DEPTH (4),
        .ADDR_W     (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .addr        (addr),
        .byteenable  (byteenable),
        .wdata       (wdata),
        .read_zfifo  (read_zfifo),
        .zfifo_in    (zfifo_in),
        .zread_empty (zread_empty),
        .axi_done    (axi_done),
        .err         (err),
        .m_araddr    (m_araddr),
        .m_arvalid   (m_arvalid),
        .m_arready   (m_arready),
        .m_rdata     (m_rdata),
        .m_rresp     (m_rresp),
        .m_rvalid    (m_rvalid),
        .m_rready    (m_rready),
        .m_awaddr    (m_awaddr),
        .m_awvalid   (m_awvalid),
        .m_awready   (m_awready),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_wvalid    (m_wvalid),
        .m_wready    (m_wready),
        .m_bresp     (m_bresp),
        .m_bvalid    (m_bvalid),
        .m_bready    (m_bready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Zero-wait read; returns in the cycle after axi_done with rd_req low.
    task automatic rd_txn(input logic [31:0] a, input logic [31:0] exp_addr,
                          input logic [31:0] d, input logic [1:0] resp);
        rd_req = 1'b1;
        addr   = a;
        tick();
        chk1("rd_arvalid", m_arvalid, 1'b1);
        chk1("rd_no_awvalid", m_awvalid, 1'b0);
        chk32("rd_araddr", m_araddr, exp_addr);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        chk1("rd_arvalid_drop", m_arvalid, 1'b0);
        chk1("rd_rready", m_rready, 1'b1);
        m_rvalid = 1'b1;
        m_rdata  = d;
        m_rresp  = resp;
        tick();
        m_rvalid = 1'b0;
        m_rresp  = 2'b00;
        chk1("rd_done", axi_done, 1'b1);
        chk1("rd_nonempty", zread_empty, 1'b0);
        tick();
        rd_req = 1'b0;
        chk1("rd_done_drop", axi_done, 1'b0);
        chk1("rd_no_reaccept", m_arvalid, 1'b0);
    endtask

    // Zero-wait write; returns in the cycle after axi_done with wr_req low.
    task automatic wr_txn(input logic [31:0] a, input logic [1:0] be, input logic [31:0] d,
                          input logic [1:0] resp, input logic [31:0] exp_addr,
                          input logic [3:0] exp_strb);
        wr_req     = 1'b1;
        addr       = a;
        byteenable = be;
        wdata      = d;
        tick();
        chk1("wr_awvalid", m_awvalid, 1'b1);
        chk1("wr_wvalid", m_wvalid, 1'b1);
        chk32("wr_awaddr", m_awaddr, exp_addr);
        chk32("wr_wstrb", {28'd0, m_wstrb}, {28'd0, exp_strb});
        chk32("wr_wdata", m_wdata, d);
        m_awready = 1'b1;
        m_wready  = 1'b1;
        tick();
        m_awready = 1'b0;
        m_wready  = 1'b0;
        chk1("wr_bready", m_bready, 1'b1);
        chk1("wr_aw_drop", m_awvalid, 1'b0);
        chk1("wr_w_drop", m_wvalid, 1'b0);
        m_bvalid = 1'b1;
        m_bresp  = resp;
        tick();
        m_bvalid = 1'b0;
        m_bresp  = 2'b00;
        chk1("wr_done", axi_done, 1'b1);
        tick();
        wr_req = 1'b0;
        chk1("wr_done_drop", axi_done, 1'b0);
        chk1("wr_no_reaccept", m_awvalid, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        rd_req = 1'b0; wr_req = 1'b0; addr = '0; byteenable = '0; wdata = '0;
        read_zfifo = 1'b0;
        m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rvalid = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bresp = '0; m_bvalid = 1'b0;

        // Reset state
        tick();
        tick();
        chk1("rst_arvalid", m_arvalid, 1'b0);
        chk1("rst_rready", m_rready, 1'b0);
        chk1("rst_awvalid", m_awvalid, 1'b0);
        chk1("rst_wvalid", m_wvalid, 1'b0);
        chk1("rst_bready", m_bready, 1'b0);
        chk1("rst_done", axi_done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_empty", zread_empty, 1'b1);
        chk32("rst_zfifo_in", zfifo_in, 32'h0);
        reset = 1'b0;
        tick();

        // Single read, zero wait
        rd_txn(32'h1000_0004, 32'h1000_0004, 32'hDEAD_BEEF, 2'b00);
        chk32("t1_head", zfifo_in, 32'hDEAD_BEEF);
        chk1("t1_err", err, 1'b0);
        read_zfifo = 1'b1;
        tick();
        read_zfifo = 1'b0;
        chk1("t1_empty_after_pop", zread_empty, 1'b1);

        // Upper-halfword write
        wr_txn(32'h0000_1236, 2'b11, 32'h1234_0000, 2'b00, 32'h0000_1234, 4'b1100);
        chk1("t2_err", err, 1'b0);

        // awready delayed 3 cycles, wready immediate
        wr_req = 1'b1; addr = 32'h0000_0022; byteenable = 2'b01; wdata = 32'h0000_ABCD;
        tick();
        chk1("t3_aw_c1", m_awvalid, 1'b1);
        chk1("t3_w_c1", m_wvalid, 1'b1);
        chk32("t3_awaddr", m_awaddr, 32'h0000_0020);
        chk32("t3_wstrb", {28'd0, m_wstrb}, 32'h0000_0004);
        m_wready = 1'b1;
        tick();
        m_wready = 1'b0;
        chk1("t3_w_c2", m_wvalid, 1'b0);
        chk1("t3_aw_c2", m_awvalid, 1'b1);
        chk1("t3_b_c2", m_bready, 1'b0);
        tick();
        chk1("t3_aw_c3", m_awvalid, 1'b1);
        chk1("t3_b_c3", m_bready, 1'b0);
        tick();
        chk1("t3_aw_c4", m_awvalid, 1'b1);
        chk1("t3_b_c4", m_bready, 1'b0);
        m_awready = 1'b1;
        tick();
        m_awready = 1'b0;
        chk1("t3_aw_c5", m_awvalid, 1'b0);
        chk1("t3_b_c5", m_bready, 1'b1);
        m_bvalid = 1'b1;
        tick();
        m_bvalid = 1'b0;
        chk1("t3_done", axi_done, 1'b1);
        tick();
        wr_req = 1'b0;
        chk1("t3_done_drop", axi_done, 1'b0);

        // Fill the FIFO, then a fifth read (with wr_req also high) stalls
        rd_txn(32'h0000_0100, 32'h0000_0100, 32'h0000_00A0, 2'b00);
        rd_txn(32'h0000_0104, 32'h0000_0104, 32'h0000_00A1, 2'b00);
        rd_txn(32'h0000_0108, 32'h0000_0108, 32'h0000_00A2, 2'b00);
        rd_txn(32'h0000_010C, 32'h0000_010C, 32'h0000_00A3, 2'b00);
        rd_req = 1'b1; wr_req = 1'b1; addr = 32'h0000_0050;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("t4_stall_ar", m_arvalid, 1'b0);
            chk1("t4_stall_aw", m_awvalid, 1'b0);
        end
        chk32("t4_head0", zfifo_in, 32'h0000_00A0);
        read_zfifo = 1'b1;
        wr_req = 1'b0;
        tick();
        read_zfifo = 1'b0;
        chk1("t4_pop_cycle_ar", m_arvalid, 1'b0);
        rd_txn(32'h0000_0050, 32'h0000_0050, 32'h0000_00A4, 2'b00);
        chk32("t4_head1", zfifo_in, 32'h0000_00A1);
        read_zfifo = 1'b1; tick(); read_zfifo = 1'b0;
        chk32("t4_head2", zfifo_in, 32'h0000_00A2);
        read_zfifo = 1'b1; tick(); read_zfifo = 1'b0;
        chk32("t4_head3", zfifo_in, 32'h0000_00A3);
        read_zfifo = 1'b1; tick(); read_zfifo = 1'b0;
        chk32("t4_head4", zfifo_in, 32'h0000_00A4);
        read_zfifo = 1'b1; tick(); read_zfifo = 1'b0;
        chk1("t4_empty", zread_empty, 1'b1);
        read_zfifo = 1'b1; tick(); read_zfifo = 1'b0;
        chk1("t4_pop_empty_ignored", zread_empty, 1'b1);

        // Read wins over simultaneous write; write then gets SLVERR
        wr_req = 1'b1; addr = 32'h0000_0200; byteenable = 2'b01; wdata = 32'h0000_7777;
        rd_txn(32'h0000_0300, 32'h0000_0300, 32'h55AA_55AA, 2'b00);
        chk1("t5_err_before", err, 1'b0);
        wr_txn(32'h0000_0200, 2'b01, 32'h0000_7777, 2'b10, 32'h0000_0200, 4'b0001);
        chk1("t5_err_set", err, 1'b1);
        rd_txn(32'h0000_0304, 32'h0000_0304, 32'h0F0F_0F0F, 2'b00);
        chk1("t5_err_sticky", err, 1'b1);
        chk32("t5_head", zfifo_in, 32'h55AA_55AA);

        // Reset while waiting in RD_DATA
        rd_req = 1'b1; addr = 32'h0000_0400;
        tick();
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        chk1("t6_in_rd_data", m_rready, 1'b1);
        reset = 1'b1;
        rd_req = 1'b0;
        tick();
        chk1("t6_rready", m_rready, 1'b0);
        chk1("t6_arvalid", m_arvalid, 1'b0);
        chk1("t6_awvalid", m_awvalid, 1'b0);
        chk1("t6_done", axi_done, 1'b0);
        chk1("t6_empty", zread_empty, 1'b1);
        chk1("t6_err_cleared", err, 1'b0);
        reset = 1'b0;
        tick();
        chk1("t6_idle_ar", m_arvalid, 1'b0);
        chk1("t6_idle_done", axi_done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hline_mem_port.md
# hline_mem_port

Memory-side responder for the horizontal-line z-buffer engine. Services the engine's single-outstanding read/write requests (rd_req/wr_req, addr, byteenable) by issuing AXI4-Lite transactions to the frame/z-buffer memory. Returns read words through an internal z-read FIFO and signals completion with a one-cycle axi_done pulse. Sits between the line FSM and the system AXI interconnect.

## Interface
- FIFO_DEPTH, 4, entries in z-read FIFO (power of two, ≥2)
- ADDR_W, 32, AXI address width
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rd_req  in  1  read request from line FSM
- wr_req  in  1  write request from line FSM
- addr  in  32  byte address of request
- byteenable  in  2  halfword lane enables for writes
- wdata  in  32  write data (z or pixel value)
- read_zfifo  in  1  pop z-read FIFO
- zfifo_in  out  32  z-read FIFO head word
- zread_empty  out  1  z-read FIFO empty
- axi_done  out  1  one-cycle completion pulse
- err  out  1  sticky: any SLVERR/DECERR response seen
- m_araddr/m_arvalid/m_arready  out/out/in  32/1/1  AXI read address
- m_rdata/m_rresp/m_rvalid/m_rready  in/in/in/out  32/2/1/1  AXI read data
- m_awaddr/m_awvalid/m_awready  out/out/in  32/1/1  AXI write address
- m_wdata/m_wstrb/m_wvalid/m_wready  out/out/out/in  32/4/1/1  AXI write data
- m_bresp/m_bvalid/m_bready  in/in/out  2/1/1  AXI write response

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE: rd_req high and FIFO has room (count < FIFO_DEPTH) -> capture addr, go RD_ADDR. Else wr_req high -> capture addr/byteenable/wdata, go WR_REQ. rd_req with FIFO full: stall in IDLE, rd_req keeps priority (wr_req not serviced while rd_req held).
- RD_ADDR: m_arvalid=1; on m_arready -> RD_DATA.
- RD_DATA: m_rready=1; on m_rvalid push m_rdata into FIFO, pulse axi_done, go IDLE.
- WR_REQ: m_awvalid and m_wvalid asserted together; each drops independently once its ready seen; when both accepted -> WR_RESP.
- WR_RESP: m_bready=1; on m_bvalid pulse axi_done, go IDLE.
- Address: m_araddr = m_awaddr = {addr[31:2],2'b00}.
- Strobe: m_wstrb = addr[1] ? {byteenable,2'b00} : {2'b00,byteenable}; m_wdata = wdata unchanged (FSM places halfword in correct lane).
- err set when m_rresp or m_bresp ≠ 0 on handshake; cleared only by reset. Read data still pushed, axi_done still pulsed.
- Requester holds rd_req/wr_req until axi_done; must drop it in the cycle after axi_done. Request seen in the axi_done cycle is not accepted (state still leaving RD_DATA/WR_RESP).
- FIFO: push and pop in same cycle legal when non-empty (count unchanged); pop when empty ignored; push never occurs when full (guarded at IDLE).

## Timing
- Reset values: all valids/readies 0, axi_done 0, err 0, zread_empty 1, zfifo_in 0, state IDLE, FIFO count 0.
- Reset mid-transaction: return to IDLE next cycle, drop all valids, flush FIFO; slave is reset by same system reset.
- Best-case read: req seen cycle 0, arvalid cycle 1, arready same cycle, rvalid cycle 2 -> axi_done cycle 3, zread_empty low cycle 3.
- Best-case write: req cycle 0, aw/w valid cycle 1 with both readies, bvalid cycle 2 -> axi_done cycle 3.
- zfifo_in is head word, valid whenever zread_empty=0 (first-word fall-through); pop takes effect next edge.
- All outputs registered except m_wstrb/m_*addr driven from captured registers.

## Structure
- Shared package hline_pkg: state enumeration, AXI resp constants (OKAY=2'b00), address-alignment helper.
- Sub-module: hline_sync_fifo (FWFT, parameterised width/depth, count output), instantiated once for z-read path.

## Test plan
- Single read, addr 0x10000004, slave returns 0xDEADBEEF with zero wait -> m_araddr 0x10000004, axi_done at cycle 3, zfifo_in 0xDEADBEEF, zread_empty 0.
- Write addr 0x00001236, byteenable 2'b11, wdata 0x12340000 -> m_awaddr 0x00001234, m_wstrb 4'b1100, one axi_done after bvalid.
- awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, WR_RESP only after both.
- Four reads with no pops (FIFO_DEPTH=4), fifth rd_req -> no arvalid until one read_zfifo, then proceeds; words pop in order.
- rd_req and wr_req both high in IDLE -> read serviced first; bresp=2'b10 on later write -> err=1 and stays 1.
- Reset asserted during RD_DATA -> next cycle all valids 0, zread_empty 1, state IDLE, no axi_done.
